injection_event_monitor: RTL
============================

Name: injection_event_monitor

Overview:
- Sits directly downstream of the fault-injection latch stage. Consumes its two latched fault flags (y1, y2 → flag_in[0], flag_in[1]).
- Per channel: counts assertion events, measures each assertion's length in clk cycles, and raises a sticky alarm when an assertion lasts too long.
- Completed assertions are queued as records in a small FIFO, drained over a valid/ready stream for the validation harness.

Parameters:
- DUR_W, 8, width of duration field and duration counters (saturating).
- CNT_W, 8, width of per-channel event counters (saturating).
- MAX_LEN, 16, duration at or above which the channel alarm sets; legal range 1..2^DUR_W-1.
- DEPTH, 4, record FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rstn  input  1  reset, synchronous, active-low.
- flag_in  input  2  fault flags from the injection stage; same clock domain, no synchronizer.
- clr  input  1  synchronous clear of evt_cnt0/1, alarm, overflow; FIFO contents untouched.
- rec_valid  output  1  FIFO non-empty.
- rec_ready  input  1  consumer accepts head record when rec_valid && rec_ready.
- rec_chan  output  1  channel of head record.
- rec_dur  output  DUR_W  duration of head record in cycles.
- evt_cnt0  output  CNT_W  rising-edge count, channel 0.
- evt_cnt1  output  CNT_W  rising-edge count, channel 1.
- alarm  output  2  sticky over-length flag per channel.
- overflow  output  1  sticky; a record was dropped because the FIFO was full.

Behaviour:
- Reset (rstn=0 at an edge):
  - All outputs 0; FIFO empty; flag_q, dur counters and pending buffer cleared.
  - rstn dominates clr and all other activity.
  - A flag already high when reset releases counts as a rising edge on the first active edge.
- Per channel i, each edge, with flag_q[i] = previous sampled flag:
  - Rise (flag=1, flag_q=0): dur_i ← 1; evt_cnt_i ← sat(evt_cnt_i+1), holding at 2^CNT_W-1.
  - High (flag=1, flag_q=1): dur_i ← sat(dur_i+1), holding at 2^DUR_W-1.
  - Fall (flag=0, flag_q=1): emit record {i, dur_i}. dur_i equals the number of edges at which the flag was sampled high.
  - flag_q[i] ← flag_in[i] every edge.
- Alarm:
  - alarm[i] ← 1 at the edge where the updated dur_i becomes ≥ MAX_LEN; the flag need not fall.
  - Sticky until clr or reset. If clr and a set condition occur at the same edge, set wins.
- Record enqueue:
  - Single write port; enqueue occurs at the fall edge itself.
  - rec_valid rises in the cycle after that edge, i.e. one cycle after flag_in is first seen low.
  - Simultaneous falls: ch0 record is enqueued; ch1 record goes into a 1-entry pending buffer and is enqueued at the next edge, ahead of any new fall.
  - The pending buffer can never be needed twice back-to-back, since a fall requires at least one high sample after a low.
- FIFO:
  - Push and pop in the same edge are both honoured, including when full, because pop frees the slot first.
  - Push while full without a pop: record dropped, overflow ← 1 (sticky, clr clears, set wins over clr).
  - Pop while empty: ignored.
  - Pointers are log2(DEPTH)+1 bits wide with wrap. Full = MSBs differ and LSBs equal.
  - rec_chan and rec_dur are driven from the head entry. When rec_valid=0 they are don't-care but are held at 0.
  - rec_chan/rec_dur are stable while rec_valid && !rec_ready.
- clr:
  - Zeroes evt counters, alarm and overflow at that edge, unless a set condition for the same bit occurs at that edge.
  - A rise coincident with clr gives evt_cnt = 1.
  - Does not affect dur counters, pending buffer or FIFO.
- Reset mid-assertion: the in-flight duration is discarded; no record is emitted.

Decomposition:
- Shared package injection_pkg:
  - record struct {chan, dur}.
  - Default widths DUR_W/CNT_W.
  - Channel count constant NUM_CH=2.
- One sub-module: inj_rec_fifo, a parameterised synchronous FIFO (DEPTH, width 1+DUR_W) with push/pop/full/empty.
- Per-channel edge/duration/counter logic goes in a generate loop inside the top.

Test Plan:
- Reset release with flag_in=2'b01 held 3 cycles, then low → evt_cnt0=1; one record {0,3}; rec_valid rises 1 cycle after first low sample; alarm=0.
- ch1 high 16 cycles, MAX_LEN=16 → alarm[1]=1 at the 16th high edge while still high; record {1,16} on fall; pulse clr → alarm=00, evt_cnt1=0, FIFO still holds the record.
- Both channels fall at the same edge (ch0 2 cycles, ch1 5 cycles) → FIFO order {0,2} then {1,5}; the second record is visible one edge later.
- rec_ready=0; 5 single-cycle pulses on ch0 with DEPTH=4 → 4 records {0,1}, overflow=1 after the 5th fall; drain all 4 → rec_valid=0.
- FIFO full with rec_ready=1 and a fall at the same edge → no drop; overflow stays 0; occupancy stays 4.
- ch0 held high 300 cycles, DUR_W=8 → record dur=255 (saturated); rstn=0 mid-pulse on a second pulse → no record emitted, all outputs 0.

Source files
------------

// File: rtl/injection_pkg.sv
// Shared types and constants for the injection event monitor and its record FIFO.
package injection_pkg;

  localparam int NUM_CH    = 2;
  localparam int DUR_W_DEF = 8;
  localparam int CNT_W_DEF = 8;

  // One completed assertion: which channel, and how many edges it was sampled high.
  typedef struct packed {
    logic                 chan;
    logic [DUR_W_DEF-1:0] dur;
  } rec_t;

  function automatic rec_t mk_rec(input logic chan, input logic [DUR_W_DEF-1:0] dur);
    rec_t r;
    r.chan = chan;
    r.dur  = dur;
    return r;
  endfunction

endpackage

// File: rtl/inj_rec_fifo.sv
// Synchronous record FIFO; a pop in the same edge frees the slot so a push while full is honoured.
module inj_rec_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_do_push;
  logic         w_do_pop;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Head is forced to zero while empty so idle outputs are deterministic.
  assign o_data = o_empty ? '0 : r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + PTR_ONE;
      if (w_do_pop)  r_rd <= r_rd + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/injection_event_monitor.sv
// Per-channel event counting, duration measurement and over-length alarm on the latched
// fault flags, with completed assertions queued as {chan, dur} records.
module injection_event_monitor
  import injection_pkg::*;
#(
  parameter int DUR_W   = DUR_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int MAX_LEN = 16,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        flag_in,
  input  logic              clr,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic              rec_chan,
  output logic [DUR_W-1:0]  rec_dur,
  output logic [CNT_W-1:0]  evt_cnt0,
  output logic [CNT_W-1:0]  evt_cnt1,
  output logic [1:0]        alarm,
  output logic              overflow
);

  // Record stream: a record transfers at a rising edge where rec_valid && rec_ready;
  // rec_chan/rec_dur hold the head entry and stay stable while rec_valid && !rec_ready.

  localparam int RW = 1 + DUR_W;
  localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);
  localparam logic [DUR_W-1:0] DUR_MAX   = {DUR_W{1'b1}};
  localparam logic [DUR_W-1:0] MAX_LEN_V = DUR_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [NUM_CH-1:0] w_fall;
  logic [NUM_CH-1:0] w_alarm;
  logic [DUR_W-1:0]  w_dur [NUM_CH];
  logic [CNT_W-1:0]  w_cnt [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic             r_flag_q;
    logic [DUR_W-1:0] r_dur;
    logic [CNT_W-1:0] r_cnt;
    logic             r_alarm;
    logic             w_rise;
    logic             w_high;
    logic             w_set;
    logic [DUR_W-1:0] w_dur_nxt;

    assign w_rise = flag_in[g] & ~r_flag_q;
    assign w_high = flag_in[g] &  r_flag_q;

    always_comb begin
      w_dur_nxt = r_dur;
      if (w_rise)                           w_dur_nxt = DUR_ONE;
      else if (w_high && r_dur != DUR_MAX)  w_dur_nxt = r_dur + DUR_ONE;
    end

    // Alarm fires on the updated duration, so it can set while the flag is still high.
    assign w_set = (w_rise | w_high) && (w_dur_nxt >= MAX_LEN_V);

    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_flag_q <= 1'b0;
        r_dur    <= '0;
        r_cnt    <= '0;
        r_alarm  <= 1'b0;
      end else begin
        r_flag_q <= flag_in[g];
        r_dur    <= w_dur_nxt;
        r_alarm  <= w_set | (r_alarm & ~clr);
        if (w_rise)
          r_cnt <= clr ? CNT_ONE : ((r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE);
        else if (clr)
          r_cnt <= '0;
      end
    end

    assign w_fall[g]  = ~flag_in[g] & r_flag_q;
    assign w_dur[g]   = r_dur;
    assign w_cnt[g]   = r_cnt;
    assign w_alarm[g] = r_alarm;
  end

  logic          r_pend_vld;
  logic [RW-1:0] r_pend_rec;
  logic          w_pend_load;
  logic          w_push;
  logic [RW-1:0] w_push_rec;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [RW-1:0] w_head;
  logic          w_drop;
  logic          r_overflow;

  // A pending ch1 record always drains the edge after a double fall; no fall can occur
  // at that edge because both flags were just sampled low.
  always_comb begin
    w_push      = 1'b0;
    w_push_rec  = '0;
    w_pend_load = 1'b0;
    if (r_pend_vld) begin
      w_push     = 1'b1;
      w_push_rec = r_pend_rec;
    end else if (w_fall[0]) begin
      w_push      = 1'b1;
      w_push_rec  = {1'b0, w_dur[0]};
      w_pend_load = w_fall[1];
    end else if (w_fall[1]) begin
      w_push     = 1'b1;
      w_push_rec = {1'b1, w_dur[1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pend_vld <= 1'b0;
      r_pend_rec <= '0;
    end else begin
      r_pend_vld <= w_pend_load;
      if (w_pend_load) r_pend_rec <= {1'b1, w_dur[1]};
    end
  end

  assign w_pop  = ~w_empty & rec_ready;
  assign w_drop = w_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (!rstn) r_overflow <= 1'b0;
    else       r_overflow <= w_drop | (r_overflow & ~clr);
  end

  inj_rec_fifo #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_data  (w_push_rec),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign rec_valid = ~w_empty;
  assign rec_chan  = w_head[RW-1];
  assign rec_dur   = w_head[DUR_W-1:0];
  assign evt_cnt0  = w_cnt[0];
  assign evt_cnt1  = w_cnt[1];
  assign alarm     = w_alarm;
  assign overflow  = r_overflow;

endmodule
